uart_modem_ctrl: RTL and testbench

UART modem-control/status stage that drives rts_pad_o/dtr_pad_o and receives cts_pad_i/dsr_pad_i/ri_pad_i/dcd_pad_i. It sits directly behind the modem pads that the modem monitor BFM observes.
It synchronises the incoming pad lines and forms the 16550-style MSR, including sticky delta bits with clear-on-read. It also implements loopback mode and raises the modem-status interrupt request.

---
 rtl/uart_modem_ctrl.sv | 44 ++++
 tb/tb_uart_modem_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/uart_modem_ctrl.sv
// uart_modem_ctrl: modem pad synchronisers, 16550-style MSR with sticky
// clear-on-read delta bits, loopback routing and modem-status interrupt.
module uart_modem_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [4:0] mcr_i,
  input  logic       msr_rd_i,
  input  logic       ms_ie_i,
  input  logic       cts_pad_i,
  input  logic       dsr_pad_i,
  input  logic       ri_pad_i,
  input  logic       dcd_pad_i,
  output logic       rts_pad_o,
  output logic       dtr_pad_o,
  output logic [7:0] msr_o,
  output logic       ms_int_o
);
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] pads, mux, ev;
  logic       loop;
  assign loop = mcr_i[4];
  assign pads = {dcd_pad_i, ri_pad_i, dsr_pad_i, cts_pad_i};
  // loopback takes {OUT2,OUT1,DTR,RTS} straight from MCR, bypassing the synchronisers
  assign mux = loop ? {mcr_i[3], mcr_i[2], mcr_i[0], mcr_i[1]} : ~sync_q[SYNC_STAGES-1];
  // TERI only fires on the trailing edge of ring (RI status 1 -> 0)
  assign ev = {mux[3] ^ msr_o[7], msr_o[6] & ~mux[2], mux[1] ^ msr_o[5], mux[0] ^ msr_o[4]};
  assign ms_int_o = ms_ie_i & |msr_o[3:0];
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
      msr_o     <= '0;
      rts_pad_o <= 1'b0;
      dtr_pad_o <= 1'b0;
    end else begin
      sync_q[0] <= pads;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      msr_o     <= {mux, (msr_rd_i ? 4'h0 : msr_o[3:0]) | ev};
      rts_pad_o <= ~loop & mcr_i[1];
      dtr_pad_o <= ~loop & mcr_i[0];
    end
  end
endmodule

// File: tb/tb_uart_modem_ctrl.sv
// tb_uart_modem_ctrl: directed plus randomized checks of uart_modem_ctrl
// against a cycle-level behavioural model of the MSR rules.
module tb_uart_modem_ctrl;
  localparam int S = 2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] mcr = '0;
  logic       rd = 1'b0, ie = 1'b1;
  logic [3:0] pads = 4'hF;
  logic       rts, dtr, ms_int;
  logic [7:0] msr;
  int n_chk = 0, n_fail = 0;
  logic [3:0] hist [$];
  logic [3:0] m_st, m_dl;
  logic       m_rts, m_dtr;

  uart_modem_ctrl #(.SYNC_STAGES(S)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .mcr_i(mcr), .msr_rd_i(rd), .ms_ie_i(ie),
    .cts_pad_i(pads[0]), .dsr_pad_i(pads[1]), .ri_pad_i(pads[2]), .dcd_pad_i(pads[3]),
    .rts_pad_o(rts), .dtr_pad_o(dtr), .msr_o(msr), .ms_int_o(ms_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back(4'hF);
    m_st = '0; m_dl = '0; m_rts = 1'b0; m_dtr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_msr"}, msr, {m_st, m_dl});
    check({tag, "_pads"}, {6'b0, rts, dtr}, {6'b0, m_rts, m_dtr});
    check({tag, "_int"}, {7'b0, ms_int}, {7'b0, ie & (m_dl != 4'h0)});
  endtask

  // called at a negedge: apply inputs, advance model by one edge, check at next negedge
  task automatic step(input string tag, input logic [4:0] m, input logic r, input logic e, input logic [3:0] p);
    logic [3:0] src, nw, ev;
    mcr = m; rd = r; ie = e; pads = p;
    src = hist.pop_front();
    hist.push_back(p);
    nw = m[4] ? {m[3], m[2], m[0], m[1]} : ~src;
    ev = '0;
    if (nw[0] != m_st[0]) ev[0] = 1'b1;
    if (nw[1] != m_st[1]) ev[1] = 1'b1;
    if (m_st[2] && !nw[2]) ev[2] = 1'b1;
    if (nw[3] != m_st[3]) ev[3] = 1'b1;
    if (r) m_dl = '0;
    m_dl |= ev;
    m_st = nw;
    m_rts = !m[4] && m[1];
    m_dtr = !m[4] && m[0];
    @(negedge clk);
    rd = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [4:0] rm;
    logic [3:0] rp;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_msr", msr, 8'h00);
    check("rst_int", {7'b0, ms_int}, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step("idle", 5'b0, 1'b0, 1'b1, 4'hF);
    check("idle_msr", msr, 8'h00);
    step("cts1", 5'b0, 1'b0, 1'b1, 4'hE);
    step("cts2", 5'b0, 1'b0, 1'b1, 4'hE);
    check("cts_2edges", msr, 8'h00);
    step("cts3", 5'b0, 1'b0, 1'b1, 4'hE);
    check("cts_3edges", msr, 8'h11);
    check("cts_int", {7'b0, ms_int}, 8'h01);
    step("rd", 5'b0, 1'b1, 1'b1, 4'hE);
    check("rd_clr", msr, 8'h10);
    check("rd_int", {7'b0, ms_int}, 8'h00);
    for (int i = 0; i < 3; i++) step("cts_rel", 5'b0, 1'b0, 1'b1, 4'hF);
    step("rd2", 5'b0, 1'b1, 1'b1, 4'hF);
    check("rd2_clr", msr, 8'h00);
    for (int i = 0; i < 3; i++) step("ri_lo", 5'b0, 1'b0, 1'b1, 4'hB);
    check("ri_lead", msr, 8'h40);
    for (int i = 0; i < 3; i++) step("ri_hi", 5'b0, 1'b0, 1'b1, 4'hF);
    check("ri_trail", msr, 8'h04);
    step("rd3", 5'b0, 1'b1, 1'b1, 4'hF);
    step("loop", 5'b10011, 1'b0, 1'b1, 4'hF);
    check("loop_msr", msr, 8'h33);
    check("loop_pads", {6'b0, rts, dtr}, 8'h00);
    for (int i = 0; i < 5; i++) step("loop_pad", 5'b10011, 1'b0, 1'b1, 4'($urandom));
    check("loop_ign", msr, 8'h33);
    step("collide", 5'b11011, 1'b1, 1'b1, 4'hF);
    check("collide_msr", msr, 8'hB8);
    rp = 4'hF;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rp = 4'($urandom);
      rm = ($urandom_range(0, 5) == 0) ? 5'($urandom) : {1'b0, mcr[3:0]};
      step("rand", rm, $urandom_range(0, 3) == 0, 1'($urandom), rp);
      if (i == 200) begin
        #2 rst = 1'b1;
        #1 check("arst_msr", msr, 8'h00);
        check("arst_pads", {6'b0, rts, dtr}, 8'h00);
        model_reset();
        rp = 4'hF; pads = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < S + 3; k++) step("post_rst", 5'b0, 1'b0, 1'b1, 4'hF);
        check("post_rst_clean", msr, 8'h00);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
